// File: rtl/intra16_recon.sv
`default_nettype none
// ============================================================================
// Module      : intra16_recon
// Description : Intra16 luma macroblock reconstruction (DC/TM/V/H prediction
//               plus residual, clipped to 8 bits), one row per cycle.
//               Optional clip counter enabled by INTRA16_RECON_CLIP_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module intra16_recon #(
    parameter int BLOCK_SIZE = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [9:0]                          x,
    input  logic [9:0]                          y,
    input  logic [31:0]                         mode_i16,
    input  logic [7:0]                          top_left,
    input  logic [8*BLOCK_SIZE-1:0]             top,
    input  logic [8*BLOCK_SIZE-1:0]             left,
    input  logic [16*BLOCK_SIZE*BLOCK_SIZE-1:0] residual,
    output logic [8*BLOCK_SIZE*BLOCK_SIZE-1:0]  out,
    output logic                                busy,
    output logic                                done
`ifdef INTRA16_RECON_CLIP_CNT_EN
    ,
    output logic [8:0]                          clip_cnt
`endif
);
    localparam int                 c_ROW_W    = $clog2(BLOCK_SIZE);
    localparam int                 c_ROW_BITS = 8 * BLOCK_SIZE;
    localparam logic [c_ROW_W-1:0] c_LAST_ROW = c_ROW_W'(BLOCK_SIZE - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_DCSUM = 2'd1;
    localparam logic [1:0] c_ST_ROW   = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    localparam logic [1:0] c_MODE_DC = 2'd0;
    localparam logic [1:0] c_MODE_TM = 2'd1;
    localparam logic [1:0] c_MODE_V  = 2'd2;

    logic [1:0]                          r_state;
    logic [1:0]                          w_next;
    logic [c_ROW_W-1:0]                  r_row;
    logic [1:0]                          r_mode;
    logic [9:0]                          r_x;
    logic [9:0]                          r_y;
    logic [7:0]                          r_tl;
    logic [7:0]                          r_dc;
    logic [c_ROW_BITS-1:0]               r_top;
    logic [c_ROW_BITS-1:0]               r_left;
    logic [16*BLOCK_SIZE*BLOCK_SIZE-1:0] r_res;
    logic [8*BLOCK_SIZE*BLOCK_SIZE-1:0]  r_out;

    logic                                w_accept;
    logic [11:0]                         w_sum_top;
    logic [11:0]                         w_sum_left;
    logic [12:0]                         w_sum_both;
    logic [12:0]                         w_top_rnd;
    logic [12:0]                         w_left_rnd;
    logic [7:0]                          w_dc;
    logic [7:0]                          w_left_px;
    logic [7:0]                          w_pred [BLOCK_SIZE];
    logic signed [17:0]                  w_sum  [BLOCK_SIZE];
    logic [c_ROW_BITS-1:0]               w_row_pix;
    logic                                w_unused_mode;

    function automatic logic signed [17:0] zx18(input logic [7:0] v);
        return $signed({10'd0, v});
    endfunction

    function automatic logic [7:0] clip255(input logic signed [17:0] v);
        if (v < 0)
            return 8'd0;
        else if (v > 18'sd255)
            return 8'd255;
        else
            return v[7:0];
    endfunction

    assign w_unused_mode = ^mode_i16[31:2];
    assign w_accept      = (r_state == c_ST_IDLE) && start;

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= c_ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE:  if (start) w_next = c_ST_DCSUM;
            c_ST_DCSUM: w_next = c_ST_ROW;
            c_ST_ROW:   if (r_row == c_LAST_ROW) w_next = c_ST_DONE;
            default:    w_next = c_ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != c_ST_IDLE);
        done = (r_state == c_ST_DONE);
    end

    always_comb begin
        w_sum_top  = '0;
        w_sum_left = '0;
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            w_sum_top  = w_sum_top  + {4'd0, r_top[8*i +: 8]};
            w_sum_left = w_sum_left + {4'd0, r_left[8*i +: 8]};
        end
        w_sum_both = {1'b0, w_sum_top} + {1'b0, w_sum_left} + 13'd16;
        w_top_rnd  = {1'b0, w_sum_top} + 13'd8;
        w_left_rnd = {1'b0, w_sum_left} + 13'd8;
        if (r_x != '0 && r_y != '0)
            w_dc = w_sum_both[12:5];
        else if (r_y != '0)
            w_dc = w_top_rnd[11:4];
        else if (r_x != '0)
            w_dc = w_left_rnd[11:4];
        else
            w_dc = 8'd128;
    end

    // One output row: prediction for row r_row plus its residual, saturated.
    always_comb begin
        w_left_px = r_left[8*r_row +: 8];
        w_row_pix = '0;
        for (int c = 0; c < BLOCK_SIZE; c++) begin
            w_pred[c] = r_dc;
            case (r_mode)
                c_MODE_DC: w_pred[c] = r_dc;
                c_MODE_TM: w_pred[c] = clip255(zx18(w_left_px) + zx18(r_top[8*c +: 8]) - zx18(r_tl));
                c_MODE_V:  w_pred[c] = r_top[8*c +: 8];
                default:   w_pred[c] = w_left_px;
            endcase
            w_sum[c] = zx18(w_pred[c])
                     + $signed({{2{r_res[(BLOCK_SIZE*r_row + c)*16 + 15]}},
                                r_res[(BLOCK_SIZE*r_row + c)*16 +: 16]});
            w_row_pix[8*c +: 8] = clip255(w_sum[c]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_row  <= '0;
            r_mode <= '0;
            r_x    <= '0;
            r_y    <= '0;
            r_tl   <= '0;
            r_dc   <= '0;
            r_top  <= '0;
            r_left <= '0;
            r_res  <= '0;
            r_out  <= '0;
        end else begin
            if (w_accept) begin
                r_mode <= mode_i16[1:0];
                r_x    <= x;
                r_y    <= y;
                r_tl   <= top_left;
                r_top  <= top;
                r_left <= left;
                r_res  <= residual;
            end
            if (r_state == c_ST_DCSUM)
                r_dc <= w_dc;
            if (r_state == c_ST_ROW) begin
                r_out[c_ROW_BITS*r_row +: c_ROW_BITS] <= w_row_pix;
                r_row <= (r_row == c_LAST_ROW) ? '0 : r_row + 1'b1;
            end
        end
    end

    assign out = r_out;

`ifdef INTRA16_RECON_CLIP_CNT_EN
    logic [8:0] r_clip_cnt;
    logic [4:0] w_row_clips;

    always_comb begin
        w_row_clips = '0;
        for (int c = 0; c < BLOCK_SIZE; c++) begin
            if (w_sum[c] < 0 || w_sum[c] > 18'sd255)
                w_row_clips = w_row_clips + 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_accept)
            r_clip_cnt <= '0;
        else if (r_state == c_ST_ROW)
            r_clip_cnt <= r_clip_cnt + {4'd0, w_row_clips};
    end

    assign clip_cnt = r_clip_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_intra16_recon.sv
`default_nettype none
// Testbench for intra16_recon: directed and random blocks checked against a
// reference model through an expected-result queue.
module tb_intra16_recon;
    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [9:0]    x;
    logic [9:0]    y;
    logic [31:0]   mode;
    logic [7:0]    tl;
    logic [127:0]  top;
    logic [127:0]  left;
    logic [4095:0] res;
    logic [2047:0] out;
    logic          busy;
    logic          done;
`ifdef INTRA16_RECON_CLIP_CNT_EN
    logic [8:0]    clip_cnt;
`endif

    typedef struct {
        logic [2047:0] img;
        int            clips;
    } exp_t;

    exp_t          exp_q[$];
    logic [2047:0] last_img;
    int            n_tests = 0;
    int            n_fail  = 0;

    intra16_recon #(.BLOCK_SIZE(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .x        (x),
        .y        (y),
        .mode_i16 (mode),
        .top_left (tl),
        .top      (top),
        .left     (left),
        .residual (res),
        .out      (out),
        .busy     (busy),
        .done     (done)
`ifdef INTRA16_RECON_CLIP_CNT_EN
        ,
        .clip_cnt (clip_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic chk_img(input string tag, input logic [2047:0] img);
        int k;
        k = 0;
        for (int i = 255; i >= 0; i--)
            if (out[8*i +: 8] !== img[8*i +: 8]) k = i;
        chk({tag, "_img"}, {24'd0, out[8*k +: 8]}, {24'd0, img[8*k +: 8]});
    endtask

    function automatic int clamp(input int v);
        return (v < 0) ? 0 : ((v > 255) ? 255 : v);
    endfunction

    task automatic model(output logic [2047:0] img, output int clips);
        int st, sl, dc, p, v;
        st = 0;
        sl = 0;
        for (int i = 0; i < 16; i++) begin
            st += int'(top[8*i +: 8]);
            sl += int'(left[8*i +: 8]);
        end
        if (x != 0 && y != 0)  dc = (st + sl + 16) >> 5;
        else if (y != 0)       dc = (st + 8) >> 4;
        else if (x != 0)       dc = (sl + 8) >> 4;
        else                   dc = 128;
        img   = '0;
        clips = 0;
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                case (mode[1:0])
                    2'd0:    p = dc;
                    2'd1:    p = clamp(int'(left[8*r +: 8]) + int'(top[8*c +: 8]) - int'(tl));
                    2'd2:    p = int'(top[8*c +: 8]);
                    default: p = int'(left[8*r +: 8]);
                endcase
                v = p + int'($signed(res[(16*r + c)*16 +: 16]));
                if (v < 0 || v > 255) clips++;
                v = clamp(v);
                img[(16*r + c)*8 +: 8] = v[7:0];
            end
        end
    endtask

    task automatic run_block(input string tag, input int glitch_at, input int rst_at,
                             input bit start_in_done);
        exp_t e;
        int   n;
        int   dcount;
        bit   aborted;
        if (rst_at == 0) begin
            model(e.img, e.clips);
            exp_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        n       = 1;
        aborted = 1'b0;
        while (!done && n < 40 && !aborted) begin
            if (n == glitch_at) begin
                start = 1'b1;
                mode  = mode ^ 32'h3;
                top   = ~top;
                left  = ~left;
            end
            if (n == rst_at) rst = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            if (rst) begin
                rst     = 1'b0;
                aborted = 1'b1;
            end else begin
                n++;
            end
        end
        if (aborted) begin
            chk({tag, "_abort_busy"}, {31'd0, busy}, 32'd0);
            chk({tag, "_abort_out"}, {31'd0, |out}, 32'd0);
            dcount = 0;
            repeat (20) begin
                @(posedge clk); #1;
                if (done) dcount++;
            end
            chk({tag, "_abort_nodone"}, dcount, 32'd0);
        end else begin
            chk({tag, "_latency"}, n, 32'd18);
            chk({tag, "_sb_depth"}, exp_q.size(), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                last_img = e.img;
                chk_img(tag, e.img);
`ifdef INTRA16_RECON_CLIP_CNT_EN
                chk({tag, "_clip_cnt"}, {23'd0, clip_cnt}, e.clips);
`endif
            end
            if (start_in_done) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
            chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        x     = '0;
        y     = '0;
        mode  = '0;
        tl    = '0;
        top   = '0;
        left  = '0;
        res   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", {31'd0, |out}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // DC with no neighbours: flat 128, neighbour values must not matter
        x = 0; y = 0; mode = 0; tl = 8'd77;
        for (int i = 0; i < 16; i++) begin
            top[8*i +: 8]  = 8'(i * 13);
            left[8*i +: 8] = 8'(200 - i);
        end
        res = '0;
        run_block("dc_none", 0, 0, 1'b0);
        chk("dc_none_px0", {24'd0, out[7:0]}, 32'd128);
        chk("dc_none_px255", {24'd0, out[2047:2040]}, 32'd128);
        x = 5; y = 7; mode = 1; top = ~top; res = {256{16'h7000}};
        repeat (4) @(posedge clk);
        #1;
        chk_img("hold_after_done", last_img);

        // DC with both neighbours, junk in ignored mode bits, start during DONE
        x = 1; y = 1; mode = 32'hFFFF_FFFC; tl = 0;
        top = {16{8'd10}}; left = {16{8'd30}}; res = '0;
        run_block("dc_both", 0, 0, 1'b1);
        chk("dc_both_px", {24'd0, out[8*100 +: 8]}, 32'd20);

        // DC top-only and left-only averages with rounding
        x = 0; y = 3; mode = 0;
        for (int i = 0; i < 16; i++) top[8*i +: 8] = 8'(i * 16 + 3);
        for (int i = 0; i < 256; i++) res[16*i +: 16] = 16'(i % 7 - 3);
        run_block("dc_top", 0, 0, 1'b0);
        x = 9; y = 0;
        for (int i = 0; i < 16; i++) left[8*i +: 8] = 8'(255 - i * 9);
        run_block("dc_left", 0, 0, 1'b0);

        // TrueMotion
        x = 2; y = 2; mode = 1; tl = 8'd100;
        top = {16{8'd200}}; left = {16{8'd150}}; res = '0;
        run_block("tm", 0, 0, 1'b0);
        chk("tm_px", {24'd0, out[8*37 +: 8]}, 32'd250);
`ifdef INTRA16_RECON_CLIP_CNT_EN
        res = {256{16'sd10}};
        run_block("tm_clip", 0, 0, 1'b0);
        chk("tm_clip_px", {24'd0, out[8*200 +: 8]}, 32'd255);
        chk("tm_clip_cnt256", {23'd0, clip_cnt}, 32'd256);
`endif

        // Vertical with negative residual clamping the low columns
        mode = 2;
        for (int i = 0; i < 16; i++) top[8*i +: 8] = 8'(i);
        res = {256{-16'sd5}};
        run_block("vert", 0, 0, 1'b0);
        chk("vert_c3", {24'd0, out[8*(16*2 + 3) +: 8]}, 32'd0);
        chk("vert_c10", {24'd0, out[8*(16*9 + 10) +: 8]}, 32'd5);

        // Horizontal with an ignored start at cycle 5
        mode = 3; res = '0;
        for (int i = 0; i < 16; i++) left[8*i +: 8] = 8'(16 * i);
        run_block("horiz", 5, 0, 1'b0);
        chk("horiz_r7", {24'd0, out[8*(16*7 + 4) +: 8]}, 32'd112);

        // Horizontal aborted by reset while row 8 is due
        mode = 3; res = '0;
        for (int i = 0; i < 16; i++) left[8*i +: 8] = 8'(16 * i);
        run_block("horiz_rst", 0, 10, 1'b0);

        // Reset wins over a simultaneous start
        @(negedge clk);
        rst = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        chk("rst_prio_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        chk("rst_prio_busy2", {31'd0, busy}, 32'd0);

        // Random blocks across all modes
        for (int t = 0; t < 6; t++) begin
            x    = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(1, 1023)) : 10'd0;
            y    = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(1, 1023)) : 10'd0;
            mode = $urandom;
            tl   = 8'($urandom);
            for (int i = 0; i < 16; i++) begin
                top[8*i +: 8]  = 8'($urandom);
                left[8*i +: 8] = 8'($urandom);
            end
            for (int i = 0; i < 256; i++)
                res[16*i +: 16] = 16'($urandom_range(0, 600) - 300);
            res[16*17 +: 16] = 16'sh7FFF;
            res[16*99 +: 16] = 16'sh8000;
            run_block("rand", 0, 0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
